// File: rtl/pcm_pkg.sv
// Shared types and width helpers for the multi-voice PCM player.
package pcm_pkg;

   // Scan sequencer states: wait for tick, then ISSUE/CAPT per voice, then OUT.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      CAPT  = 2'd2,
      OUT   = 2'd3
   } pcm_state_t;

   // Ceiling log2; clog2(1) == 0.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

   // Mixed output width: one extra bit per doubling of the voice count.
   function automatic int out_width(input int dw, input int nch);
      return dw + clog2(nch);
   endfunction

   // Channel index width, never zero so a single-voice build still has a counter bit.
   function automatic int chan_width(input int nch);
      return (nch > 1) ? clog2(nch) : 1;
   endfunction

   // Widths for the default build.
   localparam int PCM_NCH = 4;
   localparam int PCM_DW  = 8;
   localparam int PCM_OW  = PCM_DW + clog2(PCM_NCH);
   localparam int PCM_CHW = chan_width(PCM_NCH);

endpackage

// File: rtl/pcm_voice_ctx.sv
// Per-voice context: playback address, latched controls, request pending bits
// and the advance / apply-at-OUT rules.
module pcm_voice_ctx
   import pcm_pkg::*;
#(
   parameter int AW   = 15,
   parameter int VOLW = 4
) (
   input  logic            pcm_clk,
   input  logic            RESET,
   input  logic            i_kick,
   input  logic            i_stop,
   input  logic [AW-1:0]   i_start,
   input  logic [AW-1:0]   i_end,
   input  logic            i_loop,
   input  logic [VOLW-1:0] i_vol,
   input  logic            i_adv,
   input  logic            i_apply,
   output logic [AW-1:0]   o_addr,
   output logic [VOLW-1:0] o_vol,
   output logic            o_busy,
   output logic            o_done
);

   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   r_start;
   logic [AW-1:0]   r_end;
   logic            r_loop;
   logic [VOLW-1:0] r_vol;
   logic            r_busy;
   logic            r_done;
   logic            r_kick_pend;
   logic            r_stop_pend;
   logic            r_ending;

   logic            w_kick;
   logic            w_stop;
   logic            w_range_ok;
   logic [AW-1:0]   w_addr_inc;

   // Requests arriving in the OUT cycle itself are folded into that apply.
   assign w_kick     = r_kick_pend | i_kick;
   assign w_stop     = r_stop_pend | i_stop;
   assign w_range_ok = (i_start < i_end);
   assign w_addr_inc = r_addr + AW'(1);

   // Voice state: accumulate requests, step the address in CAPT, resolve everything at OUT.
   always_ff @(posedge pcm_clk or posedge RESET) begin
      if (RESET) begin
         r_addr      <= '0;
         r_start     <= '0;
         r_end       <= '0;
         r_loop      <= 1'b0;
         r_vol       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_kick_pend <= 1'b0;
         r_stop_pend <= 1'b0;
         r_ending    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_apply) begin
            r_kick_pend <= 1'b0;
            r_stop_pend <= 1'b0;
            r_ending    <= 1'b0;
            if (w_kick) begin
               // Kick wins over both a pending stop and a natural end.
               r_start <= i_start;
               r_end   <= i_end;
               r_loop  <= i_loop;
               r_vol   <= i_vol;
               r_addr  <= i_start;
               r_busy  <= w_range_ok;
               r_done  <= ~w_range_ok;
            end else begin
               if (r_ending) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
               if (w_stop) r_busy <= 1'b0;
            end
         end else begin
            r_kick_pend <= w_kick;
            r_stop_pend <= w_stop;
            if (i_adv) begin
               if (w_addr_inc == r_end) begin
                  if (r_loop) r_addr   <= r_start;
                  else        r_ending <= 1'b1;
               end else begin
                  r_addr <= w_addr_inc;
               end
            end
         end
      end
   end

   assign o_addr = r_addr;
   assign o_vol  = r_vol;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/pcm_voice_player.sv
// Multi-voice PCM player: one shared sync ROM, scanned once per output sample,
// voices mixed unsigned into a widened output.
module pcm_voice_player
   import pcm_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int AW       = 15,
   parameter int DW       = 8,
   parameter int VOLW     = 4,
   parameter int TICK_DIV = 64
) (
   input  logic                      pcm_clk,
   input  logic                      RESET,
   input  logic [NCH-1:0]            kick,
   input  logic [NCH-1:0]            stop,
   input  logic [NCH*AW-1:0]         start_addr,
   input  logic [NCH*AW-1:0]         end_addr,
   input  logic [NCH-1:0]            loop_en,
   input  logic [NCH*VOLW-1:0]       vol,
   output logic                      rom_rd,
   output logic [AW-1:0]             rom_addr,
   input  logic [DW-1:0]             rom_data,
   output logic [NCH-1:0]            busy,
   output logic [NCH-1:0]            done,
   output logic [DW+clog2(NCH)-1:0]  pcm_out,
   output logic                      pcm_valid
);

   localparam int OW  = out_width(DW, NCH);
   localparam int CHW = chan_width(NCH);
   localparam int TW  = clog2(TICK_DIV);
   localparam int PW  = DW + VOLW;

   pcm_state_t      r_state;
   logic [TW-1:0]   r_tick;
   logic [CHW-1:0]  r_ch;
   logic [OW-1:0]   r_acc;

   logic [AW-1:0]   w_addr [NCH];
   logic [VOLW-1:0] w_vol  [NCH];
   logic [NCH-1:0]  w_adv;
   logic            w_apply;
   logic            w_tick_wrap;
   logic            w_last_ch;
   logic [CHW-1:0]  w_ch_nxt;
   logic [VOLW-1:0] w_vol_sel;
   logic [PW-1:0]   w_prod;
   logic [DW-1:0]   w_contrib;

   assign w_tick_wrap = (r_tick == TW'(TICK_DIV - 1));
   assign w_apply     = (r_state == OUT);
   assign w_last_ch   = (r_ch == CHW'(NCH - 1));
   assign w_ch_nxt    = r_ch + CHW'(1);
   assign w_vol_sel   = w_vol[r_ch];
   // Scaled sample (data*vol)>>VOLW, so full volume is (2^VOLW-1)/2^VOLW.
   assign w_prod      = {{VOLW{1'b0}}, rom_data} * {{DW{1'b0}}, w_vol_sel};
   assign w_contrib   = w_prod[PW-1:VOLW];

   for (genvar gi = 0; gi < NCH; gi++) begin : g_voice
      assign w_adv[gi] = (r_state == CAPT) && (r_ch == CHW'(gi)) && busy[gi];

      pcm_voice_ctx #(
         .AW   (AW),
         .VOLW (VOLW)
      ) u_ctx (
         .pcm_clk (pcm_clk),
         .RESET   (RESET),
         .i_kick  (kick[gi]),
         .i_stop  (stop[gi]),
         .i_start (start_addr[gi*AW +: AW]),
         .i_end   (end_addr[gi*AW +: AW]),
         .i_loop  (loop_en[gi]),
         .i_vol   (vol[gi*VOLW +: VOLW]),
         .i_adv   (w_adv[gi]),
         .i_apply (w_apply),
         .o_addr  (w_addr[gi]),
         .o_vol   (w_vol[gi]),
         .o_busy  (busy[gi]),
         .o_done  (done[gi])
      );
   end

   // Tick divider, scan sequencer, registered ROM strobe/address and mixer.
   always_ff @(posedge pcm_clk or posedge RESET) begin
      if (RESET) begin
         r_state   <= IDLE;
         r_tick    <= '0;
         r_ch      <= '0;
         r_acc     <= '0;
         rom_rd    <= 1'b0;
         rom_addr  <= '0;
         pcm_out   <= '0;
         pcm_valid <= 1'b0;
      end else begin
         r_tick    <= w_tick_wrap ? '0 : r_tick + TW'(1);
         rom_rd    <= 1'b0;
         rom_addr  <= '0;
         pcm_valid <= 1'b0;
         // ROM strobe is set on entry to ISSUE so it is high exactly during ISSUE.
         case (r_state)
            IDLE: begin
               if (w_tick_wrap) begin
                  r_state  <= ISSUE;
                  r_ch     <= '0;
                  rom_rd   <= busy[0];
                  rom_addr <= busy[0] ? w_addr[0] : '0;
               end
            end
            ISSUE: begin
               r_state <= CAPT;
            end
            CAPT: begin
               if (busy[r_ch]) r_acc <= r_acc + OW'(w_contrib);
               if (w_last_ch) begin
                  r_state <= OUT;
               end else begin
                  r_state  <= ISSUE;
                  r_ch     <= w_ch_nxt;
                  rom_rd   <= busy[w_ch_nxt];
                  rom_addr <= busy[w_ch_nxt] ? w_addr[w_ch_nxt] : '0;
               end
            end
            OUT: begin
               pcm_out   <= r_acc;
               pcm_valid <= 1'b1;
               r_acc     <= '0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pcm_voice_player.md
Name: pcm_voice_player

Overview:
- Multi-channel successor to the single-shot PCM player in the Gaplus sound path.
- Plays NCH independent sample voices from one shared synchronous sample ROM.
- Per-voice start/end addresses, loop mode, volume, retrigger and stop.
- Time-multiplexes ROM reads across voices once per output sample period and mixes them into one unsigned output for the WSG aux input.

Parameters:
- NCH, 4, number of voices (≥1).
- AW, 15, sample ROM address width.
- DW, 8, sample data width (unsigned).
- VOLW, 4, per-voice volume width.
- TICK_DIV, 64, pcm_clk cycles per output sample; must be ≥ 2*NCH+2.

Ports:
- pcm_clk  in  1  clock.
- RESET  in  1  reset: asynchronous, active-high.
- kick  in  NCH  per-voice start/retrigger request; level sampled every cycle.
- stop  in  NCH  per-voice stop request.
- start_addr  in  NCH*AW  per-voice first address; voice i at bits [i*AW +: AW].
- end_addr  in  NCH*AW  per-voice end address, exclusive.
- loop_en  in  NCH  per-voice loop mode.
- vol  in  NCH*VOLW  per-voice volume.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  AW  ROM address.
- rom_data  in  DW  ROM data, valid the cycle after rom_rd.
- busy  out  NCH  voice active.
- done  out  NCH  one-cycle pulse when a non-looping voice ends.
- pcm_out  out  DW+clog2(NCH)  mixed sample.
- pcm_valid  out  1  one-cycle pulse when pcm_out updates.

Behaviour:
- Reset: all outputs 0; every voice inactive; tick counter 0; FSM in IDLE.
- Tick counter counts 0..TICK_DIV-1 and wraps. A wrap to 0 starts a scan; scans are never pre-empted.
- FSM:
  - IDLE: wait for tick.
  - ISSUE(ch): if busy[ch], drive rom_rd=1 and rom_addr=addr[ch]; otherwise rom_rd=0.
  - CAPT(ch): if busy[ch], acc += (rom_data*vol[ch])>>VOLW, then advance the voice.
  - After CAPT(NCH-1) → OUT. OUT lasts 1 cycle, then back to IDLE. A scan is 2*NCH+1 cycles.
- Voice advance: addr+1 == end → if loop_en, addr=start; else mark the voice "ending". Otherwise addr+1.
- OUT cycle, in this order:
  - pcm_out = acc; pcm_valid = 1; acc cleared.
  - Ending voices: busy=0 and done=1 for one cycle.
  - Pending requests applied: stop clears busy with no done pulse. Kick loads addr=start_addr, latches start/end/loop/vol, busy=1. Kick overrides both stop and ending in the same OUT.
  - Pending bits cleared.
- Requests: kick/stop set sticky pending bits on any cycle, OR'd across the scan. Addresses and controls are sampled at OUT, not at request time.
- Kick with start_addr ≥ end_addr: voice stays or goes inactive; done pulses in that OUT.
- Inactive voices contribute 0 and issue no ROM read. rom_rd=0 outside ISSUE states.
- Mixing: unsigned throughout; output width DW+clog2(NCH) makes overflow impossible. vol=0 contributes 0; full-scale volume is (2^VOLW-1)/2^VOLW.
- Latency: kick seen in scan n → first sample of the voice appears in pcm_out at the end of scan n+1.
- Reset mid-scan aborts immediately to the reset state; no done pulses.

Decomposition:
- Shared package pcm_pkg:
  - FSM state enum: IDLE/ISSUE/CAPT/OUT.
  - Function clog2.
  - Width localparams: OW = DW+clog2(NCH); channel index width.
- One natural sub-module, pcm_voice_ctx: per-voice registers (addr, end, loop, vol, busy, pending, ending) and advance/apply logic. It is instantiated NCH times via generate; the top holds the sequencer, ROM mux and mixer.

Test Plan:
- Single shot: NCH=4, TICK_DIV=16. Voice0 kick with start=0x100, end=0x104, vol=15, ROM[a]=0x80 → 4 pcm_valid with pcm_out=0x78 (120), then 0; done[0] pulses once; busy[0] falls in the same OUT.
- Loop: voice1 start=0x10, end=0x12, loop_en=1, ROM[0x10]=0x20, ROM[0x11]=0x40, vol=8 → outputs alternate 0x10, 0x20 indefinitely; no done. Stop → busy=0, no done, output 0 from the next scan.
- Mix: all 4 voices on ROM=0xFF with vol=15 → pcm_out=4*239=956 (10-bit). Check rom_rd pulses exactly 4 per scan with the correct addresses.
- Retrigger: kick voice0 mid-sample, with kick and stop asserted in the same cycle → restart at start_addr; kick wins; no done pulse.
- Degenerate: kick with start=0x50, end=0x50 → busy stays 0; done pulses at OUT; no ROM reads.
- Reset mid-scan during ISSUE(2) → all outputs 0 next cycle; a subsequent kick plays normally from start.
